param_sync_fifo: RTL and testbench
==================================

Name: param_sync_fifo

Overview:
- Parametrised single-clock FIFO; next generation of the team's basic 8-bit FIFO.
- Generalises data width and depth.
- Adds occupancy count, programmable almost-full/almost-empty flags and overflow/underflow error pulses.
- Used as the standard buffering element between producer/consumer stages in one clock domain.

Parameters:
- DATA_W, 8, data width in bits (>=1).
- DEPTH, 16, number of entries; power of two, >=2.
- AF_LEVEL, DEPTH-2, almost_full asserted when count >= AF_LEVEL (1..DEPTH).
- AE_LEVEL, 2, almost_empty asserted when count <= AE_LEVEL (0..DEPTH-1).

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- wr  in  1  write request.
- rd  in  1  read request.
- din  in  DATA_W  write data.
- dout  out  DATA_W  read data.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- almost_empty  out  1  count <= AE_LEVEL.
- almost_full  out  1  count >= AF_LEVEL.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  out  1  one-cycle pulse: a write was rejected.
- underflow  out  1  one-cycle pulse: a read was rejected.

Behaviour:
- Interface (already decided): one clock, clk; reset rst is asynchronous and active-low.
- Reset value while rst=0, applied immediately without waiting for a clock edge:
  - pointers 0, count 0, dout 0
  - empty 1, almost_empty 1, full 0, almost_full 0
  - overflow 0, underflow 0
  - memory contents are don't-care.
- Storage: DEPTH x DATA_W array; write and read pointers of $clog2(DEPTH) bits wrap naturally DEPTH-1 -> 0. Occupancy is tracked by count, not by pointer compare.
- Write acceptance: wr_ok = wr & (~full | rd). When accepted, din is written at wr_ptr and wr_ptr increments.
- Read acceptance: rd_ok = rd & ~empty. When accepted, rd_ptr increments.
- Count update (next cycle):
  - wr_ok & ~rd_ok: count+1
  - rd_ok & ~wr_ok: count-1
  - both or neither: unchanged.
- Flags empty/full/almost_* are registered and derived from next count, so they are valid in the same cycle as the new count. No combinational path from wr/rd to any output, except dout in FWFT mode.
- Standard (non-FWFT) read latency: dout <= mem[rd_ptr] on the edge where rd_ok=1, so data is visible 1 cycle after rd. dout holds its value when no read is accepted.
- Full with wr and rd in the same cycle: both accepted; the read returns the old head, the write fills the freed slot; count stays DEPTH; no overflow.
- Empty with wr and rd in the same cycle: the write is accepted; the read is rejected with an underflow pulse; count becomes 1.
- Rejected write (wr & full & ~rd): memory and pointers unchanged; overflow=1 for exactly the next cycle.
- Rejected read (rd & empty): pointers and dout unchanged; underflow=1 for exactly the next cycle.
- Reset asserted mid-operation: all contents discarded; outputs return to reset values asynchronously; the first write after deassertion lands at address 0.

Optional Feature:
- Macro: PARAM_SYNC_FIFO_FWFT_EN.
- Defined (first-word-fall-through):
  - dout = mem[rd_ptr] combinationally whenever empty=0, so the head word is visible without a read.
  - rd pops the head; the next word appears in the same cycle the pointer advances.
  - dout = 0 while empty.
  - Written data becomes visible on dout the cycle after the write that clears empty.
  - All flag, count and error behaviour is identical to standard mode.
- Not defined: standard 1-cycle registered read as specified above.

Test Plan:
- Reset -> with rst=0 mid-clock: empty=1, almost_empty=1, full=0, almost_full=0, count=0, dout=0, overflow=0 and underflow=0 immediately.
- Fill (DEPTH=16, AF_LEVEL=14) with writes 0x01..0x10 -> count increments 1..16; almost_full rises with count=14; full rises with count=16; almost_empty falls with count=3. A 17th write of 0xFF -> overflow pulses for 1 cycle; count stays 16.
- Drain 16 reads -> dout = 0x01..0x10 in order, 1 cycle after each rd (standard mode). A 17th read -> underflow pulses; dout holds 0x10; empty=1.
- Wrap-around: write 10 / read 10 three times with incrementing data -> no data loss or reordering across the pointer wrap; count returns to 0.
- Simultaneous events: at full, wr=rd=1 with din=0xAA -> count stays 16, no overflow, 0xAA read out last. At empty, wr=rd=1 -> count=1, underflow pulse.
- Reset mid-stream after 5 writes -> count=0 and empty=1 at once; after release, write 0x55 then read -> 0x55 returned (FWFT build: 0x55 on dout before rd).

Source files
------------

// File: rtl/param_sync_fifo_if.sv
// Producer/consumer-side bundle of the parametrised single-clock FIFO.
// master = stage driving wr/rd/din, slave = the FIFO itself.
interface param_sync_fifo_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic              wr;
    logic              rd;
    logic [DATA_W-1:0] din;
    logic [DATA_W-1:0] dout;
    logic              empty;
    logic              full;
    logic              almost_empty;
    logic              almost_full;
    logic [CW-1:0]     count;
    logic              overflow;
    logic              underflow;

    modport master (
        output wr, rd, din,
        input  dout, empty, full, almost_empty, almost_full, count, overflow, underflow
    );

    modport slave (
        input  wr, rd, din,
        output dout, empty, full, almost_empty, almost_full, count, overflow, underflow
    );
endinterface

// File: rtl/param_sync_fifo.sv
// Parametrised single-clock FIFO with occupancy count, almost flags and overflow/underflow pulses.
// Latency: dout registered 1 cycle after an accepted rd; PARAM_SYNC_FIFO_FWFT_EN makes the head combinational.
// Backpressure: writes at full are dropped unless a read frees a slot in the same cycle; reads at empty are dropped.
module param_sync_fifo #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic             clk,
    input  logic             rst,
    param_sync_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT  = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_CNT  = CW'(AE_LEVEL);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     cnt_nxt;
    logic              empty_q;
    logic              full_q;
    logic              ae_q;
    logic              af_q;
    logic              ovf_q;
    logic              udf_q;
    logic              wr_ok;
    logic              rd_ok;

    // A read in the same cycle frees the slot a write at full needs.
    assign wr_ok = bus.wr & (~full_q | bus.rd);
    assign rd_ok = bus.rd & ~empty_q;

    always_comb begin
        cnt_nxt = cnt;
        if (wr_ok && !rd_ok) begin
            cnt_nxt = cnt + CW'(1);
        end else if (rd_ok && !wr_ok) begin
            cnt_nxt = cnt - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= bus.din;
        end
    end

    // Flags are computed from cnt_nxt so they line up with the registered count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            cnt     <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            ae_q    <= 1'b1;
            af_q    <= 1'b0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            cnt     <= cnt_nxt;
            empty_q <= (cnt_nxt == '0);
            full_q  <= (cnt_nxt == CNT_MAX);
            ae_q    <= (cnt_nxt <= AE_CNT);
            af_q    <= (cnt_nxt >= AF_CNT);
            ovf_q   <= bus.wr & full_q & ~bus.rd;
            udf_q   <= bus.rd & empty_q;
        end
    end

`ifdef PARAM_SYNC_FIFO_FWFT_EN
    assign bus.dout = empty_q ? '0 : mem[rd_ptr];
`else
    logic [DATA_W-1:0] dout_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout_q <= '0;
        end else if (rd_ok) begin
            dout_q <= mem[rd_ptr];
        end
    end

    assign bus.dout = dout_q;
`endif

    assign bus.count        = cnt;
    assign bus.empty        = empty_q;
    assign bus.full         = full_q;
    assign bus.almost_empty = ae_q;
    assign bus.almost_full  = af_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = udf_q;

    a_cnt_range : assert property (@(posedge clk) disable iff (!rst) cnt <= CNT_MAX);
    a_empty_consistent : assert property (@(posedge clk) disable iff (!rst) empty_q == (cnt == '0));
    a_full_consistent : assert property (@(posedge clk) disable iff (!rst) full_q == (cnt == CNT_MAX));
endmodule

// File: tb/tb_param_sync_fifo.sv
// Randomised and directed bench for param_sync_fifo against a queue-based reference model.
// Build with +define+PARAM_SYNC_FIFO_FWFT_EN to exercise first-word-fall-through mode.
module tb_param_sync_fifo;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int AF     = 14;
    localparam int AE     = 2;
    localparam int CW     = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int vectors = 0;
    int errs    = 0;

    logic [DATA_W-1:0] q[$];
    logic [DATA_W-1:0] exp_dout = '0;
    logic              exp_ovf  = 1'b0;
    logic              exp_udf  = 1'b0;

    param_sync_fifo_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    param_sync_fifo #(
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .AF_LEVEL(AF),
        .AE_LEVEL(AE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [CW+5:0] exp_flags();
        int n;
        n = q.size();
        return {CW'(n), n == 0, n == DEPTH, n <= AE, n >= AF, exp_ovf, exp_udf};
    endfunction

    function automatic logic [CW+5:0] dut_flags();
        return {bus.count, bus.empty, bus.full, bus.almost_empty, bus.almost_full,
                bus.overflow, bus.underflow};
    endfunction

    function automatic logic [DATA_W-1:0] exp_dout_now();
`ifdef PARAM_SYNC_FIFO_FWFT_EN
        return (q.size() > 0) ? q[0] : '0;
`else
        return exp_dout;
`endif
    endfunction

    task automatic model_reset();
        q.delete();
        exp_dout = '0;
        exp_ovf  = 1'b0;
        exp_udf  = 1'b0;
    endtask

    // Applies one cycle of stimulus, then advances the model by the FIFO rules.
    task automatic drive(input logic w, input logic r, input logic [DATA_W-1:0] d);
        int n;
        logic rd_ok;
        logic wr_ok;
        bus.wr  = w;
        bus.rd  = r;
        bus.din = d;
        @(posedge clk);
        #1;
        n       = q.size();
        rd_ok   = r && (n > 0);
        wr_ok   = w && ((n < DEPTH) || r);
        exp_ovf = w && !r && (n == DEPTH);
        exp_udf = r && (n == 0);
        if (rd_ok) exp_dout = q.pop_front();
        if (wr_ok) q.push_back(d);
        bus.wr = 1'b0;
        bus.rd = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst = 1'b0;
        #1;
        model_reset();
        vectors++;
        if (dut_flags() !== exp_flags()) begin
            errs++;
            $display("FAIL reset_flags got %h want %h", dut_flags(), exp_flags());
        end
        vectors++;
        if (bus.dout !== '0) begin
            errs++;
            $display("FAIL reset_dout got %h want 00", bus.dout);
        end
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
    endtask

    task automatic test_fill();
        for (int i = 1; i <= DEPTH; i++) begin
            drive(1'b1, 1'b0, DATA_W'(i));
            vectors++;
            if (dut_flags() !== exp_flags()) begin
                errs++;
                $display("FAIL fill_flags[%0d] got %h want %h", i, dut_flags(), exp_flags());
            end
        end
        drive(1'b1, 1'b0, 8'hFF);
        vectors++;
        if (dut_flags() !== exp_flags()) begin
            errs++;
            $display("FAIL fill_overflow got %h want %h", dut_flags(), exp_flags());
        end
        drive(1'b0, 1'b0, '0);
        vectors++;
        if (dut_flags() !== exp_flags()) begin
            errs++;
            $display("FAIL fill_overflow_clear got %h want %h", dut_flags(), exp_flags());
        end
    endtask

    task automatic test_drain();
        for (int i = 0; i <= DEPTH; i++) begin
            drive(1'b0, 1'b1, '0);
            vectors++;
            if (bus.dout !== exp_dout_now()) begin
                errs++;
                $display("FAIL drain_dout[%0d] got %h want %h", i, bus.dout, exp_dout_now());
            end
            vectors++;
            if (dut_flags() !== exp_flags()) begin
                errs++;
                $display("FAIL drain_flags[%0d] got %h want %h", i, dut_flags(), exp_flags());
            end
        end
    endtask

    task automatic test_wrap();
        logic [DATA_W-1:0] d;
        d = 8'h40;
        for (int rnd = 0; rnd < 3; rnd++) begin
            for (int i = 0; i < 10; i++) begin
                drive(1'b1, 1'b0, d);
                d = d + 8'h01;
            end
            for (int i = 0; i < 10; i++) begin
                drive(1'b0, 1'b1, '0);
                vectors++;
                if (bus.dout !== exp_dout_now()) begin
                    errs++;
                    $display("FAIL wrap_dout[%0d.%0d] got %h want %h", rnd, i, bus.dout, exp_dout_now());
                end
            end
            vectors++;
            if (dut_flags() !== exp_flags()) begin
                errs++;
                $display("FAIL wrap_flags[%0d] got %h want %h", rnd, dut_flags(), exp_flags());
            end
        end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < DEPTH; i++) drive(1'b1, 1'b0, DATA_W'(8'h30 + i));
        drive(1'b1, 1'b1, 8'hAA);
        vectors++;
        if (dut_flags() !== exp_flags()) begin
            errs++;
            $display("FAIL simul_full_flags got %h want %h", dut_flags(), exp_flags());
        end
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b0, 1'b1, '0);
            vectors++;
            if (bus.dout !== exp_dout_now()) begin
                errs++;
                $display("FAIL simul_drain_dout[%0d] got %h want %h", i, bus.dout, exp_dout_now());
            end
        end
        drive(1'b1, 1'b1, 8'h5A);
        vectors++;
        if (dut_flags() !== exp_flags()) begin
            errs++;
            $display("FAIL simul_empty_flags got %h want %h", dut_flags(), exp_flags());
        end
        vectors++;
        if (bus.dout !== exp_dout_now()) begin
            errs++;
            $display("FAIL simul_empty_dout got %h want %h", bus.dout, exp_dout_now());
        end
        drive(1'b0, 1'b1, '0);
        vectors++;
        if (bus.dout !== exp_dout_now()) begin
            errs++;
            $display("FAIL simul_last_dout got %h want %h", bus.dout, exp_dout_now());
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, DATA_W'($urandom));
        #2 rst = 1'b0;
        #1;
        model_reset();
        vectors++;
        if (dut_flags() !== exp_flags()) begin
            errs++;
            $display("FAIL reset_mid_flags got %h want %h", dut_flags(), exp_flags());
        end
        vectors++;
        if (bus.dout !== '0) begin
            errs++;
            $display("FAIL reset_mid_dout got %h want 00", bus.dout);
        end
        #2 rst = 1'b1;
        drive(1'b1, 1'b0, 8'h55);
        vectors++;
        if (bus.dout !== exp_dout_now()) begin
            errs++;
            $display("FAIL reset_mid_head got %h want %h", bus.dout, exp_dout_now());
        end
        drive(1'b0, 1'b1, '0);
        vectors++;
        if (bus.dout !== exp_dout_now()) begin
            errs++;
            $display("FAIL reset_mid_read got %h want %h", bus.dout, exp_dout_now());
        end
        vectors++;
        if (dut_flags() !== exp_flags()) begin
            errs++;
            $display("FAIL reset_mid_after got %h want %h", dut_flags(), exp_flags());
        end
    endtask

    task automatic test_random();
        int wr_pct [4] = '{85, 15, 50, 97};
        int rd_pct [4] = '{30, 85, 50, 60};
        logic w;
        logic r;
        for (int ph = 0; ph < 4; ph++) begin
            for (int i = 0; i < 500; i++) begin
                w = ($urandom_range(99) < wr_pct[ph]);
                r = ($urandom_range(99) < rd_pct[ph]);
                drive(w, r, DATA_W'($urandom));
                vectors++;
                if ({dut_flags(), bus.dout} !== {exp_flags(), exp_dout_now()}) begin
                    errs++;
                    $display("FAIL random[%0d.%0d] flags/dout got %h/%h want %h/%h",
                             ph, i, dut_flags(), bus.dout, exp_flags(), exp_dout_now());
                end
            end
        end
    endtask

    initial begin
        bus.wr  = 1'b0;
        bus.rd  = 1'b0;
        bus.din = '0;
        test_reset();
        test_fill();
        test_drain();
        test_wrap();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
